// File: rtl/unidade_controle.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives per-stage strobes.
// Outputs are combinational from registered state; waits on imem_ready/dmem_ready up to MEM_TIMEOUT cycles, then traps.
module unidade_controle #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic [2:0]       estado,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH     = 3'b000,
        S_DECODE    = 3'b001,
        S_EXECUTE   = 3'b010,
        S_MEMORY    = 3'b011,
        S_WRITEBACK = 3'b100,
        S_ERRO      = 3'b110,
        S_HALT      = 3'b111
    } state_t;

    typedef enum logic [2:0] {
        C_LOAD    = 3'd0,
        C_STORE   = 3'd1,
        C_RTYPE   = 3'd2,
        C_BRANCH  = 3'd3,
        C_HALT    = 3'd4,
        C_ILLEGAL = 3'd5
    } class_t;

    state_t            r_state;
    state_t            w_next;
    class_t            r_class;
    class_t            w_class_next;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_count;
    logic              w_timeout;
    logic              w_count_en;
    logic              w_retire;

    assign estado      = r_state;
    assign instr_count = r_count;
    // The wait counter reaches MEM_TIMEOUT on this cycle if ready is still low.
    assign w_timeout   = (r_wait == WAIT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_class <= C_LOAD;
            r_wait  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_class <= w_class_next;
            if (w_next == r_state && w_count_en)
                r_wait <= r_wait + 1'b1;
            else
                r_wait <= '0;
            if (w_retire)
                r_count <= r_count + 1'b1;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_class_next = r_class;
        w_count_en   = 1'b0;
        w_retire     = 1'b0;
        imem_req     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        alu_src      = 1'b0;
        alu_op       = 2'b00;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        halted       = 1'b0;
        illegal      = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    imem_req = run;
                    if (run) begin
                        if (imem_ready) begin
                            ir_write = 1'b1;
                            pc_write = 1'b1;
                            w_next   = S_DECODE;
                        end else if (w_timeout) begin
                            w_next = S_ERRO;
                        end else begin
                            w_count_en = 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        7'b0000011: begin w_class_next = C_LOAD;    w_next = S_EXECUTE; end
                        7'b0100011: begin w_class_next = C_STORE;   w_next = S_EXECUTE; end
                        7'b0110011: begin w_class_next = C_RTYPE;   w_next = S_EXECUTE; end
                        7'b1100011: begin w_class_next = C_BRANCH;  w_next = S_EXECUTE; end
                        7'b0000000: begin w_class_next = C_HALT;    w_next = S_HALT;    end
                        default:    begin w_class_next = C_ILLEGAL; w_next = S_ERRO;    end
                    endcase
                end
                S_EXECUTE: begin
                    case (r_class)
                        C_LOAD, C_STORE: begin
                            alu_src = 1'b1;
                            w_next  = S_MEMORY;
                        end
                        C_RTYPE: begin
                            alu_op = 2'b10;
                            w_next = S_WRITEBACK;
                        end
                        C_BRANCH: begin
                            alu_op   = 2'b01;
                            pc_src   = 1'b1;
                            pc_write = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
                            w_next   = S_FETCH;
                            w_retire = 1'b1;
                        end
                        default: w_next = S_ERRO;
                    endcase
                end
                S_MEMORY: begin
                    mem_read  = (r_class == C_LOAD);
                    mem_write = (r_class == C_STORE);
                    if (dmem_ready) begin
                        w_next   = (r_class == C_LOAD) ? S_WRITEBACK : S_FETCH;
                        w_retire = (r_class != C_LOAD);
                    end else if (w_timeout) begin
                        w_next = S_ERRO;
                    end else begin
                        w_count_en = 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (r_class == C_LOAD);
                    w_next     = S_FETCH;
                    w_retire   = 1'b1;
                end
                S_ERRO:  illegal = 1'b1;
                S_HALT:  halted  = 1'b1;
                default: w_next  = S_ERRO;
            endcase
        end
    end
endmodule

// File: tb/tb_unidade_controle.sv
// Randomized instruction stream checked cycle by cycle against a transaction-level model of the control unit.
module tb_unidade_controle;
    localparam int CNT_W = 4;
    localparam int TO    = 15;

    logic             clk, reset, run, zero, imem_ready, dmem_ready;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [2:0]       estado;
    logic             imem_req, ir_write, pc_write, pc_src, alu_src;
    logic [1:0]       alu_op;
    logic             mem_read, mem_write, reg_write, mem_to_reg, halted, illegal;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] exp_cnt;
    logic [15:0]      obs;
    int               n_checks, n_errors;

    unidade_controle #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct3(funct3), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .estado(estado), .imem_req(imem_req),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src),
        .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    assign obs = {estado, imem_req, ir_write, pc_write, pc_src, alu_src, alu_op,
                  mem_read, mem_write, reg_write, mem_to_reg, halted, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] E(input logic [2:0] st, input logic req, input logic ir,
                                      input logic pcw, input logic pcs, input logic as,
                                      input logic [1:0] aop, input logic mr, input logic mw,
                                      input logic rw, input logic m2r);
        return {st, req, ir, pcw, pcs, as, aop, mr, mw, rw, m2r, st == 3'd7, st == 3'd6};
    endfunction

    // Called at posedge+1 after inputs are driven; checks mid-cycle, then advances one clock.
    task automatic cyc(input string tag, input logic [15:0] exp);
        #3;
        check(tag, 32'(obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        #2;
        check("reset_outputs", 32'(obs), 32'(E(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0)));
        check("reset_count", 32'(instr_count), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic idle(input int n);
        run = 1'b0; dmem_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            imem_ready = 1'($urandom);
            cyc("idle", E(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        end
        imem_ready = 1'b0;
    endtask

    task automatic fetch_wait(input int n);
        run = 1'b1; imem_ready = 1'b0;
        for (int i = 0; i < n; i++)
            cyc("fetch_wait", E(3'd0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    endtask

    task automatic absorb(input logic [2:0] st, input int n);
        for (int i = 0; i < n; i++) begin
            run = 1'($urandom); imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
            zero = 1'($urandom); opcode = 7'($urandom);
            cyc(st == 3'd7 ? "halt_state" : "erro_state", E(st, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        end
    endtask

    task automatic mem_phase(input logic is_ld, input int mw);
        int n;
        n = (mw < TO) ? mw : TO;
        dmem_ready = 1'b0;
        for (int i = 0; i < n; i++)
            cyc("mem_wait", E(3'd3, 0, 0, 0, 0, 0, 2'b00, is_ld, !is_ld, 0, 0));
        if (mw < TO) begin
            dmem_ready = 1'b1;
            cyc("mem_done", E(3'd3, 0, 0, 0, 0, 0, 2'b00, is_ld, !is_ld, 0, 0));
            dmem_ready = 1'b0;
        end else begin
            absorb(3'd6, 3);
        end
    endtask

    // One instruction from fetch to retirement (or trap). dead = 1 means a reset is needed.
    task automatic instr(input logic [31:0] ir, input logic z, input int fw, input int mw,
                         output logic dead);
        logic taken;
        dead = 1'b0;
        fetch_wait(fw);
        imem_ready = 1'b1;
        cyc("fetch_accept", E(3'd0, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0));
        imem_ready = 1'b0; run = 1'($urandom);
        opcode = ir[6:0]; funct3 = ir[14:12];
        cyc("decode", E(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        case (ir[6:0])
            7'h03: begin
                cyc("exec_load", E(3'd2, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0));
                mem_phase(1'b1, mw);
                if (mw < TO) begin
                    cyc("wb_load", E(3'd4, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1));
                    exp_cnt = exp_cnt + 1'b1;
                end else dead = 1'b1;
            end
            7'h23: begin
                cyc("exec_store", E(3'd2, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0));
                mem_phase(1'b0, mw);
                if (mw < TO) exp_cnt = exp_cnt + 1'b1;
                else dead = 1'b1;
            end
            7'h33: begin
                cyc("exec_rtype", E(3'd2, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0));
                cyc("wb_rtype", E(3'd4, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0));
                exp_cnt = exp_cnt + 1'b1;
            end
            7'h63: begin
                zero  = z;
                taken = (ir[14:12] == 3'd0 && z) || (ir[14:12] == 3'd1 && !z);
                cyc("exec_branch", E(3'd2, 0, 0, taken, 1, 0, 2'b01, 0, 0, 0, 0));
                exp_cnt = exp_cnt + 1'b1;
            end
            7'h00: begin
                absorb(3'd7, 4);
                dead = 1'b1;
            end
            default: begin
                absorb(3'd6, 4);
                dead = 1'b1;
            end
        endcase
        check("instr_count", 32'(instr_count), 32'(exp_cnt));
        if (!dead) check("back_to_fetch", 32'(estado), 32'd0);
    endtask

    initial begin
        logic        dead;
        logic [31:0] ir;
        logic [6:0]  op;
        int          sel;
        n_checks = 0; n_errors = 0; exp_cnt = '0;
        reset = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        zero = 1'b0; opcode = '0; funct3 = '0;
        #1;
        do_reset();

        instr(32'h002081B3, 1'b0, 0, 0, dead);       // add, 4 cycles
        instr(32'h0000A103, 1'b0, 0, 3, dead);       // lw, 3 wait cycles
        instr(32'h00208063, 1'b1, 0, 0, dead);       // beq taken
        instr(32'h00208063, 1'b0, 0, 0, dead);       // beq not taken
        instr(32'h00209063, 1'b0, 0, 0, dead);       // bne taken
        instr(32'h0020C063, 1'b1, 0, 0, dead);       // blt never taken here
        instr(32'h00112023, 1'b0, 0, 0, dead);       // sw zero-wait
        instr(32'h00112023, 1'b0, 14, 14, dead);     // ready on the last allowed cycle
        idle(100);
        fetch_wait(10);
        idle(1);
        instr(32'h002081B3, 1'b0, 10, 0, dead);      // run gap clears the fetch counter

        // Reset while a store strobe is active.
        fetch_wait(0);
        imem_ready = 1'b1;
        cyc("fetch_accept", E(3'd0, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0));
        imem_ready = 1'b0; opcode = 7'h23;
        cyc("decode", E(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        cyc("exec_store", E(3'd2, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0));
        #1;
        check("mid_mem_write", 32'(obs), 32'(E(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0)));
        reset = 1'b1;
        #1;
        check("async_reset_outputs", 32'(obs), 32'(E(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0)));
        check("async_reset_count", 32'(instr_count), 32'd0);
        @(posedge clk);
        #1;
        do_reset();

        instr(32'h002081B3, 1'b0, 0, 0, dead);
        instr(32'h00000000, 1'b0, 0, 0, dead);       // halt keeps count
        do_reset();
        instr(32'h0000007F, 1'b0, 0, 0, dead);       // illegal
        do_reset();
        instr(32'h00112023, 1'b0, 0, TO, dead);      // dmem timeout
        do_reset();
        fetch_wait(TO);
        absorb(3'd6, 2);                             // imem timeout
        do_reset();

        for (int k = 0; k < 80; k++) begin
            idle($urandom_range(0, 2));
            sel = $urandom_range(0, 21);
            if (sel < 4)       op = 7'h03;
            else if (sel < 8)  op = 7'h23;
            else if (sel < 12) op = 7'h33;
            else if (sel < 19) op = 7'h63;
            else if (sel < 20) op = 7'h00;
            else begin
                op = 7'($urandom);
                while (op == 7'h03 || op == 7'h23 || op == 7'h33 || op == 7'h63 || op == 7'h00)
                    op = 7'($urandom);
            end
            ir = $urandom;
            ir[6:0] = op;
            if (op == 7'h63) ir[14:12] = 3'($urandom_range(0, 3));
            instr(ir, 1'($urandom),
                  ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 3),
                  ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, 4), dead);
            if (dead) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
